// File: rtl/frame_buf_ctrl_pkg.sv
// Shared types and default sizes for the double-buffered frame store.
package frame_buf_ctrl_pkg;

    localparam int unsigned DefPixW     = 8;
    localparam int unsigned DefFramePix = 64;
    localparam int unsigned DefAddrW    = 6;

    // EMPTY: no complete frame yet; SHOW0/SHOW1: buffer being displayed
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StShow0 = 2'd1,
        StShow1 = 2'd2
    } state_e;

    // Display state that shows the given buffer
    function automatic state_e show_state(input logic buf_sel);
        return buf_sel ? StShow1 : StShow0;
    endfunction

endpackage

// File: rtl/frame_buf_ctrl_ram.sv
// 1W/1R synchronous frame RAM with a registered read port.
// Contents are not reset; only the read register is.
module frame_buf_ctrl_ram #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [PIX_W-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [PIX_W-1:0]  rd_data_o
);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rd_data_q;

    // Write port; storage is never cleared
    always_ff @(posedge Clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read, one cycle of latency
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/frame_buf_ctrl.sv
// Double-buffered frame store and buffer-select controller feeding FrameMUX.
// The writer fills the back buffer; the display reads the front buffer.
// Buffers swap only on FrameStart so a partial frame is never shown.
module frame_buf_ctrl
    import frame_buf_ctrl_pkg::*;
#(
    parameter int unsigned PIX_W     = DefPixW,
    parameter int unsigned FRAME_PIX = DefFramePix,
    parameter int unsigned ADDR_W    = DefAddrW
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WrValid,
    input  logic [PIX_W-1:0]  WrData,
    output logic              WrReady,
    input  logic              FrameStart,
    input  logic              PixEn,
    input  logic              BlankReq,
    output logic [ADDR_W-1:0] RdAddr,
    output logic [PIX_W-1:0]  Buf0,
    output logic [PIX_W-1:0]  Buf1,
    output logic              SelBuf0,
    output logic              SelBlank,
    output logic              SelBuf1,
    output logic              FrameRepeat
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_PIX - 1);

    state_e            state_q, state_d;
    logic              back_full_q, back_full_d;
    logic              wr_buf_q, wr_buf_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              sel_buf0_q, sel_buf0_d;
    logic              sel_blank_q, sel_blank_d;
    logic              sel_buf1_q, sel_buf1_d;
    logic              frame_repeat_q, frame_repeat_d;
    logic              wr_accept;

    assign WrReady   = ~back_full_q;
    assign wr_accept = WrValid & ~back_full_q;

    // Next-state: write pointer, buffer swap, read pointer and selects
    always_comb begin
        state_d        = state_q;
        back_full_d    = back_full_q;
        wr_buf_d       = wr_buf_q;
        wr_addr_d      = wr_addr_q;
        rd_addr_d      = rd_addr_q;
        frame_repeat_d = 1'b0;

        if (wr_accept) begin
            if (wr_addr_q == LastAddr) begin
                wr_addr_d   = '0;
                back_full_d = 1'b1;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end

        // A swap cannot coincide with a write: back_full_q blocks accepts
        if (FrameStart) begin
            if (back_full_q) begin
                state_d     = show_state(wr_buf_q);
                // The old front (or, from EMPTY, the other buffer) becomes the back
                wr_buf_d    = ~wr_buf_q;
                back_full_d = 1'b0;
            end else if (state_q != StEmpty) begin
                frame_repeat_d = 1'b1;
            end
        end

        if (FrameStart) begin
            rd_addr_d = '0;
        end else if (PixEn) begin
            rd_addr_d = (rd_addr_q == LastAddr) ? '0 : rd_addr_q + 1'b1;
        end

        sel_blank_d = BlankReq | (state_d == StEmpty);
        sel_buf0_d  = ~BlankReq & (state_d == StShow0);
        sel_buf1_d  = ~BlankReq & (state_d == StShow1);
    end

    // Control and select registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= StEmpty;
            back_full_q    <= 1'b0;
            wr_buf_q       <= 1'b0;
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            sel_buf0_q     <= 1'b0;
            sel_blank_q    <= 1'b1;
            sel_buf1_q     <= 1'b0;
            frame_repeat_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            back_full_q    <= back_full_d;
            wr_buf_q       <= wr_buf_d;
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            sel_buf0_q     <= sel_buf0_d;
            sel_blank_q    <= sel_blank_d;
            sel_buf1_q     <= sel_buf1_d;
            frame_repeat_q <= frame_repeat_d;
        end
    end

    frame_buf_ctrl_ram #(
        .PIX_W  (PIX_W),
        .DEPTH  (FRAME_PIX),
        .ADDR_W (ADDR_W)
    ) u_ram0 (
        .Clk       (Clk),
        .Reset     (Reset),
        .wr_en_i   (wr_accept & ~wr_buf_q),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (WrData),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (Buf0)
    );

    frame_buf_ctrl_ram #(
        .PIX_W  (PIX_W),
        .DEPTH  (FRAME_PIX),
        .ADDR_W (ADDR_W)
    ) u_ram1 (
        .Clk       (Clk),
        .Reset     (Reset),
        .wr_en_i   (wr_accept & wr_buf_q),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (WrData),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (Buf1)
    );

    assign RdAddr      = rd_addr_q;
    assign SelBuf0     = sel_buf0_q;
    assign SelBlank    = sel_blank_q;
    assign SelBuf1     = sel_buf1_q;
    assign FrameRepeat = frame_repeat_q;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Scoreboard bench for frame_buf_ctrl: stimulus pushes expected outputs from a
// frame-level reference model; a monitor pops and compares on the falling edge.
module tb_frame_buf_ctrl;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned FRAME_PIX = 64;
    localparam int unsigned ADDR_W    = 6;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              WrValid;
    logic [PIX_W-1:0]  WrData;
    logic              WrReady;
    logic              FrameStart;
    logic              PixEn;
    logic              BlankReq;
    logic [ADDR_W-1:0] RdAddr;
    logic [PIX_W-1:0]  Buf0;
    logic [PIX_W-1:0]  Buf1;
    logic              SelBuf0;
    logic              SelBlank;
    logic              SelBuf1;
    logic              FrameRepeat;

    frame_buf_ctrl #(
        .PIX_W     (PIX_W),
        .FRAME_PIX (FRAME_PIX),
        .ADDR_W    (ADDR_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .WrValid     (WrValid),
        .WrData      (WrData),
        .WrReady     (WrReady),
        .FrameStart  (FrameStart),
        .PixEn       (PixEn),
        .BlankReq    (BlankReq),
        .RdAddr      (RdAddr),
        .Buf0        (Buf0),
        .Buf1        (Buf1),
        .SelBuf0     (SelBuf0),
        .SelBlank    (SelBlank),
        .SelBuf1     (SelBuf1),
        .FrameRepeat (FrameRepeat)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0] sel;   // {buf0, blank, buf1}
        logic       rep;
        logic       rdy;
        int         rd;
        bit         chk;
        int         pix;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: frames, not registers
    int mem_m [2][FRAME_PIX];
    int front;      // -1 while no frame is displayable
    int back;       // buffer the writer is filling
    int wcount;     // pixels of the pending frame written so far
    int rd_m;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic wv, input logic [PIX_W-1:0] wd,
                              input logic fs, input logic pe, input logic br);
        exp_t e;
        int   rd_old;
        bit   pending;
        e.rep = 1'b0;
        e.chk = 1'b0;
        e.pix = 0;
        if (rst) begin
            front  = -1;
            back   = 0;
            wcount = 0;
            rd_m   = 0;
            e.sel  = 3'b010;
            e.rdy  = 1'b1;
            e.rd   = 0;
        end else begin
            rd_old  = rd_m;
            pending = (wcount == FRAME_PIX);
            if (wv && !pending) begin
                mem_m[back][wcount] = int'(wd);
                wcount++;
            end
            if (fs && pending) begin
                // Completed frame goes on display; writer takes the other buffer
                front  = back;
                back   = 1 - back;
                wcount = 0;
            end else if (fs && front >= 0) begin
                e.rep = 1'b1;
            end
            if (fs) rd_m = 0;
            else if (pe) rd_m = (rd_m + 1) % FRAME_PIX;
            if (br || front < 0) begin
                e.sel = 3'b010;
            end else begin
                e.sel = (front == 0) ? 3'b100 : 3'b001;
                e.chk = 1'b1;
                e.pix = mem_m[front][rd_old];
            end
            e.rdy = (wcount != FRAME_PIX);
            e.rd  = rd_m;
        end
        exp_q.push_back(e);
    endtask

    // Called at posedge+1: drive inputs, let the edge consume them, log expectation
    task automatic step(input logic wv, input logic [PIX_W-1:0] wd, input logic fs,
                        input logic pe, input logic br);
        WrValid    = wv;
        WrData     = wd;
        FrameStart = fs;
        PixEn      = pe;
        BlankReq   = br;
        @(posedge Clk);
        model_step(Reset, wv, wd, fs, pe, br);
        #1;
    endtask

    task automatic idle(input int n, input bit sweep);
        for (int i = 0; i < n; i++) begin
            step(1'b0, '0, 1'b0, sweep ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    // Write n pixels with random gaps; the last may be merged with FrameStart
    task automatic write_pixels(input int n, input bit rnd, input int base, input bit fs_last);
        logic [PIX_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                step(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            d = rnd ? PIX_W'($urandom) : PIX_W'(base + i);
            step(1'b1, d, (fs_last && i == n - 1) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic frame_start();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: compare each expectation one half-cycle after its edge
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sel", int'({SelBuf0, SelBlank, SelBuf1}), int'(e.sel));
                check("frame_repeat", int'(FrameRepeat), int'(e.rep));
                check("wr_ready", int'(WrReady), int'(e.rdy));
                check("rd_addr", int'(RdAddr), e.rd);
                if (e.chk) begin
                    check(e.sel[2] ? "buf0_pix" : "buf1_pix",
                          int'(e.sel[2] ? Buf0 : Buf1), e.pix);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset      = 1'b1;
        WrValid    = 1'b0;
        WrData     = '0;
        FrameStart = 1'b0;
        PixEn      = 1'b0;
        BlankReq   = 1'b0;
        repeat (2) begin
            @(posedge Clk);
            model_step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
            #1;
        end
        Reset = 1'b0;

        // No frame yet: FrameStart must neither show nor repeat
        for (int k = 0; k < 3; k++) begin
            idle(4, 1'b0);
            frame_start();
        end
        idle(3, 1'b0);

        // Frame A = 0..63 into buffer 0, then display sweep
        write_pixels(FRAME_PIX, 1'b0, 0, 1'b0);
        idle(3, 1'b0);
        frame_start();
        idle(FRAME_PIX + 3, 1'b1);

        // Frame B = 100+i while buffer 0 is shown
        write_pixels(FRAME_PIX, 1'b0, 100, 1'b0);
        frame_start();
        idle(FRAME_PIX + 3, 1'b1);

        // Third frame with no FrameStart: back fills, then writes are refused
        write_pixels(FRAME_PIX, 1'b1, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, PIX_W'($urandom), 1'b0, 1'b1, 1'b0);
        end
        frame_start();
        idle(FRAME_PIX + 2, 1'b1);

        // Last write coincides with FrameStart: repeat now, swap on the next one
        write_pixels(FRAME_PIX - 1, 1'b1, 0, 1'b0);
        write_pixels(1, 1'b1, 0, 1'b1);
        idle(5, 1'b1);
        frame_start();
        idle(FRAME_PIX + 2, 1'b1);

        // Blank request while buffer 1 is shown; reads keep advancing
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Asynchronous reset mid-frame
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check("async_blank", int'(SelBlank), 1);
        check("async_rd_addr", int'(RdAddr), 0);
        check("async_buf0_sel", int'(SelBuf0 | SelBuf1), 0);
        @(posedge Clk);
        model_step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        Reset = 1'b0;
        write_pixels(FRAME_PIX / 2, 1'b1, 0, 1'b0);
        frame_start();
        idle(4, 1'b0);
        write_pixels(FRAME_PIX - FRAME_PIX / 2, 1'b1, 0, 1'b0);
        frame_start();
        idle(FRAME_PIX + 2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 9) < 6), PIX_W'($urandom),
                 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 19) == 0));
        end

        @(negedge Clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
